// File: rtl/ci_div_issuer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ci_div_issuer_pkg
//  Brief    : Shared constants for the divide custom-instruction issuer:
//             FSM state encoding, CI data width, default divide-by-zero quotient.
//  Revision : 1.0  initial release
// ============================================================================
package ci_div_issuer_pkg;

  // Width of every data word exchanged with the divider slave
  localparam int CI_DATA_W = 32;

  // Quotient reported when the denominator is zero (slave is never started)
  localparam logic [CI_DATA_W-1:0] ZERO_DIV_Q_DEF = 32'hFFFF_FFFF;

  // Issuer FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage : ci_div_issuer_pkg
`default_nettype wire

// File: rtl/ci_div_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : ci_div_issuer
//  Brief    : Fabric-side initiator for the multi-cycle divide custom-instruction
//             slave. Takes one request over valid/ready, pulses start, waits for
//             done or a timeout, and returns the quotient over valid/ready.
//             All outputs are decoded from registered state only.
//  Revision : 1.0  initial release
// ============================================================================
module ci_div_issuer
  import ci_div_issuer_pkg::*;
#(
  parameter int                    TIMEOUT    = 64,
  parameter logic [CI_DATA_W-1:0]  ZERO_DIV_Q = ZERO_DIV_Q_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // request channel
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CI_DATA_W-1:0] req_num,
  input  logic [CI_DATA_W-1:0] req_den,
  // custom-instruction master port
  output logic                 ci_clk_en,
  output logic                 ci_start,
  output logic [CI_DATA_W-1:0] ci_dataa,
  output logic [CI_DATA_W-1:0] ci_datab,
  input  logic [CI_DATA_W-1:0] ci_result,
  input  logic                 ci_done,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CI_DATA_W-1:0] rsp_quot,
  output logic                 rsp_err
);

  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [CI_DATA_W-1:0] num_q,   num_d;
  logic [CI_DATA_W-1:0] den_q,   den_d;
  logic [CI_DATA_W-1:0] quot_q,  quot_d;
  logic                 err_q,   err_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // Next-state logic: request capture, issue, done/timeout wait, response hold
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    quot_d  = quot_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          num_d = req_num;
          den_d = req_den;
          if (req_den == '0) begin
            // Divide-by-zero is answered locally; the slave is never started
            quot_d  = ZERO_DIV_Q;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (ci_done) begin
          // Zero-latency slave answers during the start cycle
          quot_d  = ci_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ci_done) begin
          // Done takes priority over a timeout expiring in the same cycle
          quot_d  = ci_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          quot_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quot_q  <= quot_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded purely from registered state; clk_en drops in RESP so
  // the slave clears its internal state before the next operation.
  assign req_ready = (state_q == ST_IDLE);
  assign ci_start  = (state_q == ST_ISSUE);
  assign ci_clk_en = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ci_dataa  = num_q;
  assign ci_datab  = den_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_quot  = quot_q;
  assign rsp_err   = err_q;

endmodule : ci_div_issuer
`default_nettype wire

// File: tb/tb_ci_div_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ci_div_issuer
//  Brief    : Self-checking bench for ci_div_issuer with a behavioural divider
//             slave of programmable latency and a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ci_div_issuer;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] ZQ      = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_num;
  logic [31:0] req_den;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [31:0] ci_result;
  logic        ci_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_quot;
  logic        rsp_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ci_div_issuer #(.TIMEOUT(TIMEOUT), .ZERO_DIV_Q(ZQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_num   (req_num),
    .req_den   (req_den),
    .ci_clk_en (ci_clk_en),
    .ci_start  (ci_start),
    .ci_dataa  (ci_dataa),
    .ci_datab  (ci_datab),
    .ci_result (ci_result),
    .ci_done   (ci_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_quot  (rsp_quot),
    .rsp_err   (rsp_err)
  );

  // Behavioural divider slave: done arrives sl_lat cycles after start
  // (0 = same cycle), result is garbage except while done is high.
  int          sl_lat    = 0;
  bit          sl_never  = 1'b0;
  bit          sl_inject = 1'b0;
  bit          sl_busy   = 1'b0;
  int          sl_age    = 0;
  logic [31:0] sl_a      = '0;
  logic [31:0] sl_b      = '0;

  function automatic logic [31:0] sl_div(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'h0 : a / b;
  endfunction

  always @(posedge clk) begin
    if (!ci_clk_en) begin
      sl_busy <= 1'b0;
    end else if (ci_start) begin
      sl_busy <= 1'b1;
      sl_age  <= 1;
      sl_a    <= ci_dataa;
      sl_b    <= ci_datab;
    end else if (sl_busy) begin
      sl_age  <= sl_age + 1;
    end
  end

  assign ci_done = sl_inject |
                   (!sl_never && ((ci_start && sl_lat == 0) ||
                                  (sl_busy && !ci_start && sl_age == sl_lat)));
  assign ci_result = sl_inject ? 32'hDEAD_BEEF :
                     !ci_done  ? 32'h5A5A_5A5A :
                     ci_start  ? sl_div(ci_dataa, ci_datab) : sl_div(sl_a, sl_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response; expected values come from the
  // operation-level rules: quotient, error flag and accept-to-valid latency.
  task automatic run_txn(input logic [31:0] num, input logic [31:0] den,
                         input int lat, input bit never, input int hold);
    bit          to;
    logic [31:0] eq;
    logic        ee;
    int          el, es, cyc, starts;
    to = never || (lat > TIMEOUT);
    if (den == 0)  begin eq = ZQ;        ee = 1'b1; el = 1;           es = 0; end
    else if (to)   begin eq = 32'h0;     ee = 1'b1; el = 2 + TIMEOUT; es = 1; end
    else           begin eq = num / den; ee = 1'b0; el = 2 + lat;     es = 1; end

    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    sl_lat    = lat;
    sl_never  = never;
    req_valid = 1'b1;
    req_num   = num;
    req_den   = den;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    req_num   = $urandom;
    req_den   = $urandom;
    cyc       = 1;
    starts    = 0;
    while (!rsp_valid && cyc < 400) begin
      if (ci_start) starts++;
      chk("busy_req_ready", req_ready, 0);
      chk("busy_clk_en", ci_clk_en, 1);
      chk("busy_dataa", ci_dataa, num);
      chk("busy_datab", ci_datab, den);
      step();
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("latency", cyc, el);
    chk("start_pulses", starts, es);
    chk("rsp_quot", rsp_quot, eq);
    chk("rsp_err", rsp_err, ee);
    chk("resp_clk_en", ci_clk_en, 0);
    chk("resp_start", ci_start, 0);
    chk("resp_req_ready", req_ready, 0);
    chk("resp_dataa", ci_dataa, num);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_quot", rsp_quot, eq);
      chk("hold_err", rsp_err, ee);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_num   = '0;
    req_den   = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_clk_en", ci_clk_en, 0);
    chk("rst_start", ci_start, 0);
    chk("rst_quot", rsp_quot, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_dataa", ci_dataa, 0);
    chk("rst_datab", ci_datab, 0);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_txn(32'd100, 32'd7, 5, 1'b0, 0);
    run_txn(32'd5, 32'd0, 0, 1'b0, 0);
    run_txn(32'd1000, 32'd10, 3, 1'b0, 20);
    run_txn(32'd9, 32'd3, 0, 1'b0, 0);
    run_txn(32'd77, 32'd7, TIMEOUT, 1'b0, 0);
    run_txn(32'd77, 32'd7, TIMEOUT + 1, 1'b0, 0);

    // Timeout, then a late done must not produce another response
    run_txn(32'd123, 32'd4, 0, 1'b1, 1);
    repeat (9) step();
    sl_inject = 1'b1;
    step();
    sl_inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stray_rsp_valid", rsp_valid, 0);
      chk("stray_req_ready", req_ready, 1);
      step();
    end

    // Reset while waiting on the slave
    sl_never  = 1'b0;
    sl_lat    = 40;
    req_valid = 1'b1;
    req_num   = 32'd50;
    req_den   = 32'd5;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    chk("wait_clk_en", ci_clk_en, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_clk_en", ci_clk_en, 0);
    chk("midrst_start", ci_start, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 45; i++) begin
      step();
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    run_txn(32'd81, 32'd9, 3, 1'b0, 0);

    // Randomised traffic
    for (int n = 0; n < 30; n++) begin
      logic [31:0] rn, rd;
      int          rl;
      bit          rv;
      rn = $urandom;
      case ($urandom_range(0, 4))
        0:       rd = 32'd0;
        1:       rd = $urandom;
        default: rd = $urandom_range(1, 1000);
      endcase
      rl = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                       : $urandom_range(0, 9);
      rv = ($urandom_range(0, 14) == 0);
      run_txn(rn, rd, rl, rv, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_ci_div_issuer
`default_nettype wire
